// File: rtl/lane_overlay_stream.sv
// Avalon-ST lane overlay stage.
// Sits behind the Hough lane detector: VIP control and other non-video packets
// pass through untouched, while video pixels lying within HALF_THICK of either
// lane line are replaced with LINE_COLOR. The lane geometry is sampled once per
// frame on the video type beat and stepped row by row with Q8.8 accumulators.
module lane_overlay_stream #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter int WIDTH            = 512,
    parameter int HEIGHT           = 288,
    parameter int HALF_THICK       = 2,
    parameter logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] LINE_COLOR = 24'h00FF00
) (
    input  logic                                        clk,
    input  logic                                        rst,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic                                        dout_sop,
    output logic                                        dout_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    input  logic                                        lane_valid,
    input  logic [15:0]                                 left_x_top,
    input  logic [15:0]                                 left_dx,
    input  logic [15:0]                                 right_x_top,
    input  logic [15:0]                                 right_dx
);

    localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam logic [15:0] COL_LAST   = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LIMIT  = 16'(HEIGHT);
    localparam logic [17:0] THICK_LIM  = 18'(HALF_THICK);

    typedef enum logic [1:0] {
        IDLE,
        VIDEO,
        OTHER
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    col_q, col_d;
    logic [15:0]    row_q, row_d;
    logic [23:0]    acc_l_q, acc_l_d;
    logic [23:0]    acc_r_q, acc_r_d;
    logic [15:0]    dx_l_q, dx_l_d;
    logic [15:0]    dx_r_q, dx_r_d;
    logic           overlay_en_q, overlay_en_d;
    logic           dout_valid_q, dout_valid_d;
    logic           dout_sop_q, dout_sop_d;
    logic           dout_eop_q, dout_eop_d;
    logic [DW-1:0]  dout_data_q, dout_data_d;

    logic           accept;
    logic           is_video_type;
    logic [15:0]    xl, xr;
    logic signed [17:0] diff_l, diff_r;
    logic [17:0]    mag_l, mag_r;
    logic           overlay_hit;

    assign din_ready     = !dout_valid_q || dout_ready;
    assign accept        = din_valid && din_ready;
    assign is_video_type = (din_data[3:0] == 4'd0) && !din_eop;

    assign dout_valid = dout_valid_q;
    assign dout_sop   = dout_sop_q;
    assign dout_eop   = dout_eop_q;
    assign dout_data  = dout_data_q;

    // Distance of the current column to each lane line, in signed 18-bit space so off-screen lines never alias
    always_comb begin
        xl          = acc_l_q[23:8];
        xr          = acc_r_q[23:8];
        diff_l      = $signed({2'b00, col_q}) - $signed({{2{xl[15]}}, xl});
        diff_r      = $signed({2'b00, col_q}) - $signed({{2{xr[15]}}, xr});
        mag_l       = diff_l[17] ? 18'(-diff_l) : 18'(diff_l);
        mag_r       = diff_r[17] ? 18'(-diff_r) : 18'(diff_r);
        overlay_hit = overlay_en_q && (row_q < ROW_LIMIT) &&
                      ((mag_l <= THICK_LIM) || (mag_r <= THICK_LIM));
    end

    // Packet-type state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next packet state: a sop always restarts packet handling, an eop always closes it
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (din_sop) begin
                if (is_video_type) begin
                    state_d = VIDEO;
                end else if (!din_eop) begin
                    state_d = OTHER;
                end else begin
                    state_d = IDLE;
                end
            end else if (din_eop) begin
                state_d = IDLE;
            end
        end
    end

    // Raster position and lane accumulators: seeded on the video type beat, stepped per pixel
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        acc_l_d      = acc_l_q;
        acc_r_d      = acc_r_q;
        dx_l_d       = dx_l_q;
        dx_r_d       = dx_r_q;
        overlay_en_d = overlay_en_q;
        if (accept && din_sop && is_video_type) begin
            overlay_en_d = lane_valid;
            dx_l_d       = left_dx;
            dx_r_d       = right_dx;
            acc_l_d      = {left_x_top, 8'h00};
            acc_r_d      = {right_x_top, 8'h00};
            col_d        = 16'd0;
            row_d        = 16'd0;
        end else if (accept && !din_sop && (state_q == VIDEO)) begin
            if (col_q == COL_LAST) begin
                col_d   = 16'd0;
                acc_l_d = acc_l_q + {{8{dx_l_q[15]}}, dx_l_q};
                acc_r_d = acc_r_q + {{8{dx_r_q[15]}}, dx_r_q};
                if (row_q != ROW_LIMIT) begin
                    row_d = row_q + 16'd1;
                end
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    // Output register: loads on every accepted beat, drains when the sink takes it
    always_comb begin
        dout_valid_d = dout_valid_q;
        dout_sop_d   = dout_sop_q;
        dout_eop_d   = dout_eop_q;
        dout_data_d  = dout_data_q;
        if (accept) begin
            dout_valid_d = 1'b1;
            dout_sop_d   = din_sop;
            dout_eop_d   = din_eop;
            if ((state_q == VIDEO) && !din_sop && overlay_hit) begin
                dout_data_d = LINE_COLOR;
            end else begin
                dout_data_d = din_data;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // Datapath and output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= 16'd0;
            row_q        <= 16'd0;
            acc_l_q      <= 24'd0;
            acc_r_q      <= 24'd0;
            dx_l_q       <= 16'd0;
            dx_r_q       <= 16'd0;
            overlay_en_q <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_data_q  <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            dx_l_q       <= dx_l_d;
            dx_r_q       <= dx_r_d;
            overlay_en_q <= overlay_en_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            dout_data_q  <= dout_data_d;
        end
    end

endmodule

// File: tb/tb_lane_overlay_stream.sv
// Testbench for lane_overlay_stream on a small 8x4 raster.
// Packets are queued as beat records; the expected output stream is computed
// from the lane-line geometry (pixel index -> row/col, line x from Q8.8 slope)
// when each packet is queued, and compared beat by beat as the sink takes them.
module tb_lane_overlay_stream;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int HT = 1;
   localparam logic [23:0] COLOR = 24'h00FF00;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        dinReady;
   logic        dinValid = 1'b0;
   logic        dinSop = 1'b0;
   logic        dinEop = 1'b0;
   logic [23:0] dinData = 24'd0;
   logic        doutReady = 1'b0;
   logic        doutValid;
   logic        doutSop;
   logic        doutEop;
   logic [23:0] doutData;
   logic        laneValid = 1'b0;
   logic [15:0] leftXTop = 16'd0;
   logic [15:0] leftDx = 16'd0;
   logic [15:0] rightXTop = 16'd0;
   logic [15:0] rightDx = 16'd0;

   typedef struct {
      logic        sop;
      logic        eop;
      logic [23:0] data;
      logic        lv;
      logic [15:0] lxt;
      logic [15:0] ldx;
      logic [15:0] rxt;
      logic [15:0] rdx;
   } beat_t;

   beat_t       inQ[$];
   logic [25:0] expQ[$];
   int          checkCount = 0;
   int          errorCount = 0;
   int          beatNum = 0;

   lane_overlay_stream #(
      .WIDTH(W),
      .HEIGHT(H),
      .HALF_THICK(HT)
   ) dut (
      .clk(clock),
      .rst(reset),
      .din_ready(dinReady),
      .din_valid(dinValid),
      .din_sop(dinSop),
      .din_eop(dinEop),
      .din_data(dinData),
      .dout_ready(doutReady),
      .dout_valid(doutValid),
      .dout_sop(doutSop),
      .dout_eop(doutEop),
      .dout_data(doutData),
      .lane_valid(laneValid),
      .left_x_top(leftXTop),
      .left_dx(leftDx),
      .right_x_top(rightXTop),
      .right_dx(rightDx)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic int absInt(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Lane x on row r: floor of (top + r*slope) with slope in Q8.8
   function automatic int lineX(input logic [15:0] top, input logic [15:0] dx, input int r);
      int acc;
      acc = int'(top) * 256 + r * int'($signed(dx));
      return acc >>> 8;
   endfunction

   // Random lane sideband, used on beats where the DUT must ignore it
   task automatic randomLanes(output logic lv, output logic [15:0] lxt, output logic [15:0] ldx,
                              output logic [15:0] rxt, output logic [15:0] rdx);
      lv  = 1'($urandom);
      lxt = 16'($urandom);
      ldx = 16'($urandom);
      rxt = 16'($urandom);
      rdx = 16'($urandom);
   endtask

   // Queue a video packet and its expected overlay output
   task automatic addVideo(input logic lv, input logic [15:0] lxt, input logic [15:0] ldx,
                           input logic [15:0] rxt, input logic [15:0] rdx, input int nPix,
                           input bit fixedPix, input logic [23:0] pix, input bit dropEop);
      beat_t       b;
      int          r;
      int          c;
      bit          hit;
      logic [23:0] p;
      b = '{sop: 1'b1, eop: (nPix == 0), data: 24'h000000, lv: lv, lxt: lxt, ldx: ldx, rxt: rxt, rdx: rdx};
      inQ.push_back(b);
      expQ.push_back({b.sop, b.eop, b.data});
      for (int k = 0; k < nPix; k++) begin
         r   = k / W;
         c   = k % W;
         p   = fixedPix ? pix : 24'($urandom);
         hit = lv && (r < H) &&
               ((absInt(c - lineX(lxt, ldx, r)) <= HT) || (absInt(c - lineX(rxt, rdx, r)) <= HT));
         b.sop  = 1'b0;
         b.eop  = (k == nPix - 1) && !dropEop;
         b.data = p;
         randomLanes(b.lv, b.lxt, b.ldx, b.rxt, b.rdx);
         inQ.push_back(b);
         expQ.push_back({1'b0, b.eop, hit ? COLOR : p});
      end
   endtask

   // Queue a non-video packet, expected to pass bit-identically
   task automatic addOther(input logic [3:0] typeNibble, input int nBeats);
      beat_t b;
      for (int k = 0; k < nBeats; k++) begin
         b.sop  = (k == 0);
         b.eop  = (k == nBeats - 1);
         b.data = (k == 0) ? {20'($urandom), typeNibble} : 24'($urandom);
         randomLanes(b.lv, b.lxt, b.ldx, b.rxt, b.rdx);
         inQ.push_back(b);
         expQ.push_back({b.sop, b.eop, b.data});
      end
   endtask

   // Queue beats outside any packet, expected to pass unchanged
   task automatic addLoose(input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.sop  = 1'b0;
         b.eop  = 1'($urandom);
         b.data = 24'($urandom);
         randomLanes(b.lv, b.lxt, b.ldx, b.rxt, b.rdx);
         inQ.push_back(b);
         expQ.push_back({b.sop, b.eop, b.data});
      end
   endtask

   // Drive source beat idx (or an idle cycle) and a random sink ready
   task automatic presentBeat(input int idx, input int validPct, input int readyPct);
      beat_t b;
      if (idx < inQ.size() && ($urandom_range(0, 99) < validPct)) begin
         b = inQ[idx];
         dinValid  = 1'b1;
         dinSop    = b.sop;
         dinEop    = b.eop;
         dinData   = b.data;
         laneValid = b.lv;
         leftXTop  = b.lxt;
         leftDx    = b.ldx;
         rightXTop = b.rxt;
         rightDx   = b.rdx;
      end else begin
         dinValid = 1'b0;
         dinSop   = 1'($urandom);
         dinEop   = 1'($urandom);
         dinData  = 24'($urandom);
         randomLanes(laneValid, leftXTop, leftDx, rightXTop, rightDx);
      end
      doutReady = ($urandom_range(0, 99) < readyPct);
   endtask

   // Stream the queued beats through the DUT, scoring each beat the sink takes.
   // With acceptLimit>0 it stops right after that many beats have been accepted.
   task automatic applyStimulus(input int validPct, input int readyPct, input int acceptLimit);
      int          idx;
      int          cycles;
      bit          accepted;
      logic [25:0] e;
      idx    = 0;
      cycles = 0;
      presentBeat(idx, validPct, readyPct);
      while (cycles < 5000) begin
         @(negedge clock);
         if (doutValid && doutReady) begin
            if (expQ.size() == 0) begin
               checkOutput("extra beat", 32'({doutSop, doutEop, doutData}), 32'hFFFFFFFF);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("beat%0d", beatNum), 32'({doutSop, doutEop, doutData}), 32'(e));
               beatNum++;
            end
         end
         accepted = dinValid && dinReady;
         @(posedge clock);
         #1;
         if (accepted) idx++;
         if (acceptLimit > 0 && idx >= acceptLimit) begin
            dinValid = 1'b0;
            break;
         end
         if (idx >= inQ.size() && expQ.size() == 0) begin
            dinValid = 1'b0;
            break;
         end
         presentBeat(idx, validPct, readyPct);
         cycles++;
      end
      if (acceptLimit == 0) begin
         checkOutput("all accepted", 32'(idx), 32'(inQ.size()));
         checkOutput("drained", 32'(expQ.size()), 32'd0);
      end
      inQ.delete();
   endtask

   initial begin
      logic [15:0] dxl;
      logic [15:0] dxr;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst dout_valid", 32'(doutValid), 32'd0);
      checkOutput("rst dout_sop", 32'(doutSop), 32'd0);
      checkOutput("rst dout_eop", 32'(doutEop), 32'd0);
      checkOutput("rst dout_data", 32'(doutData), 32'd0);
      checkOutput("rst din_ready", 32'(dinReady), 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Two straight lanes, one slanted at one pixel per row
      addVideo(1'b1, 16'd2, 16'h0100, 16'd6, 16'h0000, 32, 1'b1, 24'h123456, 1'b0);
      applyStimulus(100, 100, 0);

      // Control packet, then a frame whose sideband churns after the type beat
      addOther(4'hF, 9);
      addVideo(1'b1, 16'd2, 16'h0100, 16'd6, 16'h0000, 32, 1'b1, 24'h123456, 1'b0);
      applyStimulus(100, 100, 0);

      // Overlay disabled: video passes unchanged
      addVideo(1'b0, 16'd2, 16'h0100, 16'd6, 16'h0000, 32, 1'b1, 24'h123456, 1'b0);
      applyStimulus(100, 100, 0);

      // Random geometry, frame lengths, packet mix and backpressure
      for (int f = 0; f < 4; f++) begin
         dxl = 16'($urandom_range(0, 1024) - 512);
         dxr = 16'($urandom_range(0, 1024) - 512);
         addVideo(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 10)), dxl,
                  16'($urandom_range(0, 10)), dxr, (f == 2) ? 40 : ((f == 3) ? 20 : 32),
                  1'b0, 24'h0, (f == 0));
         addOther(4'($urandom_range(1, 15)), $urandom_range(1, 6));
         if ($urandom_range(0, 1) == 1) addLoose($urandom_range(1, 3));
      end
      addVideo(1'b1, 16'd3, 16'h0000, 16'd4, 16'h0000, 0, 1'b0, 24'h0, 1'b0);
      addLoose(2);
      addVideo(1'b1, 16'd1, 16'h0100, 16'd5, 16'hFF00, 32, 1'b0, 24'h0, 1'b0);
      applyStimulus(60, 50, 0);

      // Negative half-pixel slope from the left edge
      addVideo(1'b1, 16'd0, 16'hFF80, 16'd6, 16'h0000, 32, 1'b1, 24'h123456, 1'b0);
      applyStimulus(100, 100, 0);

      // Stalled sink: one beat held, input must be refused until the sink takes it
      dinValid  = 1'b1;
      dinSop    = 1'b0;
      dinEop    = 1'b0;
      dinData   = 24'hA5A5A5;
      doutReady = 1'b0;
      @(posedge clock);
      #1;
      dinData = 24'h5A5A5A;
      @(negedge clock);
      checkOutput("stall valid", 32'(doutValid), 32'd1);
      checkOutput("stall din_ready", 32'(dinReady), 32'd0);
      @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput("stall hold data", 32'(doutData), 32'hA5A5A5);
      checkOutput("stall din_ready2", 32'(dinReady), 32'd0);
      dinValid  = 1'b0;
      doutReady = 1'b1;
      #1;
      checkOutput("release din_ready", 32'(dinReady), 32'd1);
      @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput("drain valid", 32'(doutValid), 32'd0);
      @(posedge clock);
      #1;

      // Reset in the middle of a frame, after the 10th pixel
      addVideo(1'b1, 16'd2, 16'h0100, 16'd6, 16'h0000, 32, 1'b1, 24'h123456, 1'b0);
      applyStimulus(100, 100, 11);
      reset = 1'b1;
      #1;
      checkOutput("midrst valid", 32'(doutValid), 32'd0);
      expQ.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      addLoose(5);
      addVideo(1'b1, 16'd3, 16'h0080, 16'd5, 16'hFF00, 32, 1'b0, 24'h0, 1'b0);
      applyStimulus(80, 70, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
